// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - debounced key levels to one-at-a-time press events
//
// Turns debounced key levels into single press events. It keeps at most one
// queued press per key and presents queued presses one at a time over a
// valid/ready handshake. Grants are round-robin, and a hold-off gap follows
// every accepted event.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   key_in       debounced key levels, 1 = pressed
//   ev_ready     consumer accepts the presented event
//   clr_overrun  synchronous clear of the sticky overrun flags
//   ev_valid     an event is presented
//   ev_id        index of the presented key
//   ev_onehot    one-hot of the presented key, 0 when ev_valid = 0
//   pending      presses queued but not yet presented
//   overrun      sticky per-key flag: a press was lost
//   busy         high while presenting or in the hold-off gap
module key_event_arbiter #(
   parameter int NUM_KEYS   = 4,
   parameter int ID_W       = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic                ev_ready,
   input  logic                clr_overrun,
   output logic                ev_valid,
   output logic [ID_W-1:0]     ev_id,
   output logic [NUM_KEYS-1:0] ev_onehot,
   output logic [NUM_KEYS-1:0] pending,
   output logic [NUM_KEYS-1:0] overrun,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

   state_t              state, state_next;
   logic [NUM_KEYS-1:0] key_prev;
   logic [ID_W-1:0]     rr_ptr, rr_ptr_next;
   logic [7:0]          gap_cnt, gap_cnt_next;

   logic                ev_valid_next;
   logic [ID_W-1:0]     ev_id_next;
   logic [NUM_KEYS-1:0] ev_onehot_next;
   logic [NUM_KEYS-1:0] pending_next;
   logic [NUM_KEYS-1:0] overrun_next;
   logic                busy_next;

   logic [NUM_KEYS-1:0] rise;
   logic [NUM_KEYS-1:0] capture_mask;
   logic [NUM_KEYS-1:0] ovr_set;
   logic [NUM_KEYS-1:0] grant_onehot;
   logic [ID_W-1:0]     grant_id;
   logic                grant_found;
   logic [ID_W:0]       cand_sum;
   logic [ID_W-1:0]     cand;

   assign rise = key_in & ~key_prev;

   // Round-robin search: first pending key at or above rr_ptr, wrapping.
   // rr_ptr and k are both below NUM_KEYS, so one subtraction wraps the sum.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand_sum >= (ID_W+1)'(NUM_KEYS))
            cand_sum = cand_sum - (ID_W+1)'(NUM_KEYS);
         cand = cand_sum[ID_W-1:0];
         if (!grant_found && pending[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   assign grant_onehot = NUM_KEYS'(1) << grant_id;
   assign capture_mask = (state == IDLE && grant_found) ? grant_onehot : '0;

   // A rise on the key being captured this cycle re-queues it without overrun.
   assign pending_next = (pending & ~capture_mask) | rise;
   assign ovr_set      = rise & pending & ~capture_mask;
   assign overrun_next = (clr_overrun ? '0 : overrun) | ovr_set;

   always_comb begin
      state_next     = state;
      ev_valid_next  = ev_valid;
      ev_id_next     = ev_id;
      ev_onehot_next = ev_onehot;
      rr_ptr_next    = rr_ptr;
      gap_cnt_next   = gap_cnt;
      case (state)
         IDLE: begin
            if (grant_found) begin
               ev_id_next     = grant_id;
               ev_onehot_next = grant_onehot;
               ev_valid_next  = 1'b1;
               state_next     = PRESENT;
            end
         end
         PRESENT: begin
            if (ev_valid && ev_ready) begin
               ev_valid_next  = 1'b0;
               ev_onehot_next = '0;
               rr_ptr_next    = (ev_id == ID_W'(NUM_KEYS - 1)) ? '0 : ev_id + 1'b1;
               if (GAP_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  state_next   = GAP;
                  gap_cnt_next = GAP_LOAD;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 8'd0)
               state_next = IDLE;
            else
               gap_cnt_next = gap_cnt - 8'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy_next = (state_next != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         key_prev  <= '1;
         rr_ptr    <= '0;
         gap_cnt   <= 8'd0;
         ev_valid  <= 1'b0;
         ev_id     <= '0;
         ev_onehot <= '0;
         pending   <= '0;
         overrun   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         key_prev  <= key_in;
         rr_ptr    <= rr_ptr_next;
         gap_cnt   <= gap_cnt_next;
         ev_valid  <= ev_valid_next;
         ev_id     <= ev_id_next;
         ev_onehot <= ev_onehot_next;
         pending   <= pending_next;
         overrun   <= overrun_next;
         busy      <= busy_next;
      end
   end

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed self-checking bench for key_event_arbiter
module tb_key_event_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] key_in;
   logic       ev_ready;
   logic       clr_overrun;
   logic       ev_valid;
   logic [1:0] ev_id;
   logic [3:0] ev_onehot;
   logic [3:0] pending;
   logic [3:0] overrun;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   key_event_arbiter #(.NUM_KEYS(4), .ID_W(2), .GAP_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in),
      .ev_ready    (ev_ready),
      .clr_overrun (clr_overrun),
      .ev_valid    (ev_valid),
      .ev_id       (ev_id),
      .ev_onehot   (ev_onehot),
      .pending     (pending),
      .overrun     (overrun),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset       = 1'b0;
      key_in      = 4'b0000;
      ev_ready    = 1'b0;
      clr_overrun = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      reset       = 1'b0;
      key_in      = 4'b0001;
      ev_ready    = 1'b0;
      clr_overrun = 1'b0;
      tick();
      tick();
      n_checks++; if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ev_valid: got %b expected 0", ev_valid); end
      n_checks++; if (ev_id !== 2'd0) begin n_errors++; $display("FAIL rst_ev_id: got %0d expected 0", ev_id); end
      n_checks++; if (ev_onehot !== 4'b0000) begin n_errors++; $display("FAIL rst_ev_onehot: got %b expected 0000", ev_onehot); end
      n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL rst_pending: got %b expected 0000", pending); end
      n_checks++; if (overrun !== 4'b0000) begin n_errors++; $display("FAIL rst_overrun: got %b expected 0000", overrun); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (ev_valid !== 1'b0 || pending !== 4'b0000) begin
            n_errors++; $display("FAIL held_through_reset cycle %0d: got valid %b pending %b expected 0 0000", i, ev_valid, pending);
         end
      end
      key_in = 4'b0000;
      tick();
      key_in = 4'b0001;
      tick();
      n_checks++; if (pending !== 4'b0001 || ev_valid !== 1'b0) begin
         n_errors++; $display("FAIL rise_latency1: got pending %b valid %b expected 0001 0", pending, ev_valid);
      end
      tick();
      n_checks++; if (ev_valid !== 1'b1) begin n_errors++; $display("FAIL rise_latency2_valid: got %b expected 1", ev_valid); end
      n_checks++; if (ev_id !== 2'd0) begin n_errors++; $display("FAIL rise_id: got %0d expected 0", ev_id); end
      n_checks++; if (ev_onehot !== 4'b0001) begin n_errors++; $display("FAIL rise_onehot: got %b expected 0001", ev_onehot); end
      n_checks++; if (busy !== 1'b1 || pending !== 4'b0000) begin
         n_errors++; $display("FAIL rise_busy_pending: got busy %b pending %b expected 1 0000", busy, pending);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_checks++; if (ev_valid !== 1'b0 || ev_onehot !== 4'b0000) begin
         n_errors++; $display("FAIL accept_drop: got valid %b onehot %b expected 0 0000", ev_valid, ev_onehot);
      end
      key_in = 4'b0000;
   endtask

   task automatic test_back_to_back;
      int         rise_cyc [4];
      logic [1:0] ids [4];
      logic [3:0] ohs [4];
      int         n_ev;
      logic       prev_valid;
      do_reset();
      n_ev       = 0;
      prev_valid = 1'b0;
      ev_ready   = 1'b1;
      key_in     = 4'b1111;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (ev_valid && !prev_valid) begin
            if (n_ev < 4) begin
               rise_cyc[n_ev] = c;
               ids[n_ev]      = ev_id;
               ohs[n_ev]      = ev_onehot;
            end
            n_ev++;
         end
         prev_valid = ev_valid;
      end
      ev_ready = 1'b0;
      n_checks++; if (n_ev !== 4) begin n_errors++; $display("FAIL b2b_count: got %0d events expected 4", n_ev); end
      for (int i = 0; i < 4; i++) begin
         if (i < n_ev) begin
            n_checks++; if (ids[i] !== 2'(i)) begin n_errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", i, ids[i], i); end
            n_checks++; if (ohs[i] !== (4'b0001 << i)) begin n_errors++; $display("FAIL b2b_onehot[%0d]: got %b expected %b", i, ohs[i], 4'b0001 << i); end
            if (i > 0) begin
               n_checks++; if (rise_cyc[i] - rise_cyc[i-1] !== 6) begin
                  n_errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 6", i, rise_cyc[i] - rise_cyc[i-1]);
               end
            end
         end
      end
      n_checks++; if (pending !== 4'b0000 || overrun !== 4'b0000 || busy !== 1'b0) begin
         n_errors++; $display("FAIL b2b_end: got pending %b overrun %b busy %b expected 0000 0000 0", pending, overrun, busy);
      end
   endtask

   task automatic test_hold;
      do_reset();
      key_in = 4'b0100;
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2 || ev_onehot !== 4'b0100) begin
            n_errors++; $display("FAIL hold cycle %0d: got valid %b id %0d onehot %b expected 1 2 0100", i, ev_valid, ev_id, ev_onehot);
         end
         tick();
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_checks++; if (ev_valid !== 1'b0 || busy !== 1'b1) begin
         n_errors++; $display("FAIL hold_accept: got valid %b busy %b expected 0 1", ev_valid, busy);
      end
   endtask

   task automatic test_overrun;
      do_reset();
      key_in = 4'b0001;
      tick();
      tick();
      key_in = 4'b0011;
      tick();
      n_checks++; if (pending !== 4'b0010 || overrun !== 4'b0000) begin
         n_errors++; $display("FAIL ovr_first: got pending %b overrun %b expected 0010 0000", pending, overrun);
      end
      key_in = 4'b0001;
      tick();
      key_in = 4'b0011;
      tick();
      n_checks++; if (overrun !== 4'b0010 || pending !== 4'b0010 || ev_id !== 2'd0) begin
         n_errors++; $display("FAIL ovr_set: got overrun %b pending %b id %0d expected 0010 0010 0", overrun, pending, ev_id);
      end
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      n_checks++; if (overrun !== 4'b0000) begin n_errors++; $display("FAIL ovr_clear: got %b expected 0000", overrun); end
      key_in = 4'b0001;
      tick();
      key_in      = 4'b0011;
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      n_checks++; if (overrun !== 4'b0010) begin n_errors++; $display("FAIL ovr_set_beats_clear: got %b expected 0010", overrun); end
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      n_checks++; if (overrun !== 4'b0000) begin n_errors++; $display("FAIL ovr_clear2: got %b expected 0000", overrun); end
   endtask

   task automatic test_wrap;
      do_reset();
      key_in = 4'b1000;
      tick();
      tick();
      key_in = 4'b0000;
      tick();
      key_in = 4'b1001;
      tick();
      n_checks++; if (ev_id !== 2'd3 || pending !== 4'b1001 || overrun !== 4'b0000) begin
         n_errors++; $display("FAIL wrap_setup: got id %0d pending %b overrun %b expected 3 1001 0000", ev_id, pending, overrun);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_gap1 cycle %0d: got valid %b expected 0", i, ev_valid); end
      end
      tick();
      n_checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0 || pending !== 4'b1000) begin
         n_errors++; $display("FAIL wrap_grant0: got valid %b id %0d pending %b expected 1 0 1000", ev_valid, ev_id, pending);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_gap2 cycle %0d: got valid %b expected 0", i, ev_valid); end
      end
      tick();
      n_checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd3 || ev_onehot !== 4'b1000 || pending !== 4'b0000) begin
         n_errors++; $display("FAIL wrap_grant3: got valid %b id %0d onehot %b pending %b expected 1 3 1000 0000", ev_valid, ev_id, ev_onehot, pending);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      key_in = 4'b0001;
      tick();
      tick();
      key_in = 4'b0111;
      tick();
      n_checks++; if (ev_valid !== 1'b1 || pending !== 4'b0110 || busy !== 1'b1) begin
         n_errors++; $display("FAIL areset_setup: got valid %b pending %b busy %b expected 1 0110 1", ev_valid, pending, busy);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (ev_valid !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0 || ev_onehot !== 4'b0000) begin
         n_errors++; $display("FAIL areset_immediate: got valid %b pending %b busy %b onehot %b expected 0 0000 0 0000", ev_valid, pending, busy, ev_onehot);
      end
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (ev_valid !== 1'b0 || pending !== 4'b0000) begin
            n_errors++; $display("FAIL areset_after cycle %0d: got valid %b pending %b expected 0 0000", i, ev_valid, pending);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      key_in      = 4'b0000;
      ev_ready    = 1'b0;
      clr_overrun = 1'b0;
      test_reset();
      test_back_to_back();
      test_hold();
      test_overrun();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Sits between the 4-key debouncer and the vending control FSM in the candy vending system. Converts debounced key levels into single press events, queues at most one pending press per key, and hands them one at a time to the vending FSM over a valid/ready handshake. Round-robin arbitration and a post-accept hold-off gap keep simultaneous presses fair and ordered.

## Interface
- NUM_KEYS, 4: number of debounced key lines; 2..8.
- ID_W, 2: width of ev_id; equals clog2(NUM_KEYS).
- GAP_CYCLES, 4: idle cycles enforced after each accepted event; 0..255, 0 = no gap.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- key_in  in  NUM_KEYS  debounced key levels (debouncer key_out), 1 = pressed.
- ev_ready  in  1  vending FSM accepts the presented event.
- clr_overrun  in  1  synchronous clear of overrun flags.
- ev_valid  out  1  an event is presented.
- ev_id  out  ID_W  index of presented key.
- ev_onehot  out  NUM_KEYS  one-hot of presented key; 0 when ev_valid = 0.
- pending  out  NUM_KEYS  queued-but-not-presented presses.
- overrun  out  NUM_KEYS  sticky: a press was lost on that key.
- busy  out  1  high in PRESENT or GAP.

## Operation
- key_prev register samples key_in every cycle; rise[i] = key_in[i] & ~key_prev[i]. key_prev resets to all ones: a key held through reset generates no event.
- rise[i] sets pending[i]. rise[i] with pending[i] already 1 (and not being captured this cycle) sets overrun[i]; pending stays 1.
- States: IDLE, PRESENT, GAP.
- IDLE: if pending != 0, select first set bit searching from rr_ptr upward with wrap; register ev_id/ev_onehot, clear that pending bit, ev_valid <= 1, go PRESENT. Else stay.
- PRESENT: ev_valid, ev_id, ev_onehot held stable while ev_ready = 0. On ev_valid & ev_ready: ev_valid <= 0, rr_ptr <= ev_id + 1 (mod NUM_KEYS); go GAP with gap_cnt <= GAP_CYCLES - 1, or IDLE if GAP_CYCLES = 0.
- GAP: gap_cnt decrements; at 0 go IDLE. Rises still queue during GAP and PRESENT.
- Simultaneous capture-clear and rise on same key: set wins, pending[i] = 1, no overrun.
- clr_overrun = 1 clears all overrun bits; a new overrun in the same cycle wins (bit stays 1).
- ev_ready while ev_valid = 0 is ignored.

## Timing
- Reset values: ev_valid 0, ev_id 0, ev_onehot 0, pending 0, overrun 0, busy 0, rr_ptr 0, gap_cnt 0, state IDLE, key_prev all ones.
- key_in rise sampled at edge t -> pending[i] = 1 after t -> ev_valid = 1 after edge t+1 (2-cycle latency, state IDLE, no other pending).
- Accept at edge a -> ev_valid = 0 after a; next ev_valid earliest after edge a + GAP_CYCLES + 1 (a + 1 when GAP_CYCLES = 0).
- Zero combinational paths from inputs to outputs; all outputs registered.
- Reset asserted mid-PRESENT or mid-GAP: all outputs drop to reset values asynchronously; queued presses discarded.

## Test plan
- Reset low, key_in = 0001 held, release reset -> no event; drop and re-raise bit 0 -> ev_valid high 2 cycles after rise, ev_id = 0, ev_onehot = 0001.
- key_in 0000 -> 1111 in one cycle, ev_ready = 1, GAP_CYCLES = 4 -> events in order id 0,1,2,3, consecutive ev_valid rising edges 6 cycles apart, pending ends 0000.
- Present id 2 with ev_ready = 0 for 10 cycles -> ev_valid, ev_id = 2, ev_onehot = 0100 stable all 10 cycles; accept on cycle 11.
- With ev_ready = 0, press key 1 twice (release between) while id 1 already pending -> overrun = 0010; clr_overrun pulse -> overrun = 0000.
- After accepting id 3, pending = 1001 -> next grant id 0 (wrap); after id 0, pending 1000 -> id 3.
- Reset asserted while PRESENT with pending = 0110 -> ev_valid, pending, busy = 0 immediately; after release, no events without new rises.
